packet_sum_accumulator: RTL and testbench

//  Stream stage directly downstream of the 16-bit hierarchical carry-lookahead adder.

---
 rtl/packet_sum_accumulator.sv | 114 +++++++++++
 tb/tb_packet_sum_accumulator.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_sum_accumulator.sv
// Packet sum accumulator: sums a valid/ready packet of words modulo 2^WIDTH,
// counts carry-outs and words with saturating counters, and presents one
// held result per packet on a valid/ready output port.
module packet_sum_accumulator #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [CNT_W-1:0] out_carries,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] carries_q, carries_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] out_sum_q, out_sum_d;
    logic [CNT_W-1:0] out_carries_q, out_carries_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;

    logic             accept;
    logic [WIDTH:0]   add_res;
    logic [CNT_W-1:0] carry_inc;

    assign in_ready    = (state_q != DONE);
    assign out_valid   = (state_q == DONE);
    assign out_sum     = out_sum_q;
    assign out_carries = out_carries_q;
    assign out_count   = out_count_q;

    // Next-state and datapath: accumulate on accept, latch result on entering DONE
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        carries_d     = carries_q;
        count_d       = count_q;
        out_sum_d     = out_sum_q;
        out_carries_d = out_carries_q;
        out_count_d   = out_count_q;
        accept        = in_valid & in_ready;
        add_res       = {1'b0, acc_q} + {1'b0, in_data};
        carry_inc     = {{(CNT_W-1){1'b0}}, add_res[WIDTH]};

        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d     = in_data;
                    carries_d = '0;
                    count_d   = CNT_W'(1);
                    state_d   = in_last ? DONE : ACC;
                end
            end
            ACC: begin
                if (accept) begin
                    acc_d     = add_res[WIDTH-1:0];
                    carries_d = (carries_q == '1) ? carries_q : carries_q + carry_inc;
                    count_d   = (count_q == '1) ? count_q : count_q + CNT_W'(1);
                    state_d   = in_last ? DONE : ACC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Result registers load the post-update values so the last word is included
        if (accept && in_last) begin
            out_sum_d     = acc_d;
            out_carries_d = carries_d;
            out_count_d   = count_d;
        end
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            carries_q     <= '0;
            count_q       <= '0;
            out_sum_q     <= '0;
            out_carries_q <= '0;
            out_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            carries_q     <= carries_d;
            count_q       <= count_d;
            out_sum_q     <= out_sum_d;
            out_carries_q <= out_carries_d;
            out_count_q   <= out_count_d;
        end
    end

endmodule

// File: tb/tb_packet_sum_accumulator.sv
// Testbench for packet_sum_accumulator: two instances (CNT_W=8 and CNT_W=2)
// share one stimulus stream; results are compared with a packet-level model.
module tb_packet_sum_accumulator;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_ready;

    logic        a_in_ready, a_out_valid;
    logic [15:0] a_out_sum;
    logic [7:0]  a_out_carries, a_out_count;

    logic        b_in_ready, b_out_valid;
    logic [15:0] b_out_sum;
    logic [1:0]  b_out_carries, b_out_count;

    int unsigned passed;
    int unsigned total;

    // model state for the packet in progress
    longint unsigned pkt_total;
    int unsigned     pkt_n;
    logic [15:0]     exp_sum;
    longint unsigned exp_carries;
    int unsigned     exp_count;

    packet_sum_accumulator #(.WIDTH(16), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_last(in_last),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_sum(a_out_sum), .out_carries(a_out_carries), .out_count(a_out_count)
    );

    packet_sum_accumulator #(.WIDTH(16), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_last(in_last),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_sum(b_out_sum), .out_carries(b_out_carries), .out_count(b_out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint unsigned sat(input longint unsigned v, input int unsigned w);
        longint unsigned mx;
        mx = (64'd1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Drive one word, wait (bounded) for acceptance, and update the model
    task automatic send_word(input logic [15:0] d, input logic last);
        int unsigned n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        n = 0;
        while (!a_in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!a_in_ready) chk("accept_timeout", 32'(a_in_ready), 32'd1);
        tick();
        pkt_total += longint'(d);
        pkt_n++;
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_last  = 1'($urandom);
        if (last) begin
            exp_sum     = pkt_total[15:0];
            exp_carries = pkt_total >> 16;
            exp_count   = pkt_n;
            pkt_total   = 0;
            pkt_n       = 0;
        end
    endtask

    task automatic check_result(input string tag);
        chk({tag, "_valid"},    32'(a_out_valid), 32'd1);
        chk({tag, "_sum"},      32'(a_out_sum), 32'(exp_sum));
        chk({tag, "_carries"},  32'(a_out_carries), 32'(sat(exp_carries, 8)));
        chk({tag, "_count"},    32'(a_out_count), 32'(sat(64'(exp_count), 8)));
        chk({tag, "_valid2"},   32'(b_out_valid), 32'd1);
        chk({tag, "_sum2"},     32'(b_out_sum), 32'(exp_sum));
        chk({tag, "_carries2"}, 32'(b_out_carries), 32'(sat(exp_carries, 2)));
        chk({tag, "_count2"},   32'(b_out_count), 32'(sat(64'(exp_count), 2)));
        chk({tag, "_in_ready"}, 32'(a_in_ready), 32'd0);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(a_out_valid), 32'd0);
        chk({tag, "_sum_kept"},   32'(a_out_sum), 32'(exp_sum));
        chk({tag, "_ready_back"}, 32'(a_in_ready), 32'd1);
    endtask

    initial begin
        int unsigned len;
        passed    = 0;
        total     = 0;
        pkt_total = 0;
        pkt_n     = 0;
        exp_sum   = '0;
        exp_carries = 0;
        exp_count = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // reset state
        #1;
        chk("rst_valid",   32'(a_out_valid), 32'd0);
        chk("rst_sum",     32'(a_out_sum), 32'd0);
        chk("rst_carries", 32'(a_out_carries), 32'd0);
        chk("rst_count",   32'(a_out_count), 32'd0);
        chk("rst_ready",   32'(a_in_ready), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // single-word packet
        send_word(16'h1234, 1'b1);
        check_result("t1");
        chk("t1_sum_const", 32'(a_out_sum), 32'h1234);
        handshake("t1");

        // back-to-back packet with one wrap
        send_word(16'hFFFF, 1'b0);
        send_word(16'h0001, 1'b0);
        chk("t2_not_valid_mid", 32'(a_out_valid), 32'd0);
        send_word(16'h0002, 1'b1);
        check_result("t2");
        chk("t2_sum_const",     32'(a_out_sum), 32'h0002);
        chk("t2_carries_const", 32'(a_out_carries), 32'd1);
        chk("t2_count_const",   32'(a_out_count), 32'd3);

        // back-pressure: input offered while result is held
        in_valid = 1'b1;
        in_data  = 16'h0007;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_hold_valid", 32'(a_out_valid), 32'd1);
            chk("t3_hold_sum",   32'(a_out_sum), 32'h0002);
            chk("t3_hold_ready", 32'(a_in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t3_valid_drop", 32'(a_out_valid), 32'd0);
        chk("t3_ready_up",   32'(a_in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        exp_sum = 16'h0007;
        exp_carries = 0;
        exp_count = 1;
        check_result("t3");
        handshake("t3");

        // gap inside a packet
        send_word(16'h0010, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_gap_valid", 32'(a_out_valid), 32'd0);
        end
        send_word(16'h0020, 1'b1);
        check_result("t4");
        handshake("t4");

        // reset mid-packet discards the partial packet
        send_word(16'h8000, 1'b0);
        send_word(16'h9000, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid",   32'(a_out_valid), 32'd0);
        chk("t5_rst_sum",     32'(a_out_sum), 32'd0);
        chk("t5_rst_carries", 32'(a_out_carries), 32'd0);
        chk("t5_rst_count",   32'(a_out_count), 32'd0);
        pkt_total = 0;
        pkt_n     = 0;
        tick();
        rst_n = 1'b1;
        tick();
        send_word(16'h0005, 1'b1);
        check_result("t5");
        handshake("t5");

        // counter saturation (CNT_W=2 instance saturates at 3)
        for (int i = 0; i < 5; i++) send_word(16'hFFFF, (i == 4));
        check_result("t6");
        chk("t6_sum_const",  32'(b_out_sum), 32'hFFFB);
        chk("t6_car_sat",    32'(b_out_carries), 32'd3);
        chk("t6_cnt_sat",    32'(b_out_count), 32'd3);
        chk("t6_car_true",   32'(a_out_carries), 32'd4);
        handshake("t6");

        // randomized packets with gaps and output back-pressure
        for (int p = 0; p < 25; p++) begin
            len = $urandom_range(1, 8);
            for (int w = 0; w < int'(len); w++) begin
                repeat ($urandom_range(0, 2)) tick();
                send_word(($urandom_range(0, 1) == 1) ? 16'($urandom_range(16'hC000, 16'hFFFF))
                                                      : 16'($urandom),
                          (w == int'(len) - 1));
            end
            check_result("rnd");
            repeat ($urandom_range(0, 3)) begin
                tick();
                chk("rnd_hold_valid", 32'(a_out_valid), 32'd1);
                chk("rnd_hold_sum",   32'(a_out_sum), 32'(exp_sum));
            end
            handshake("rnd");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
